// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int CMD_WR_BIT = 7;
    localparam int ADDR_W     = 7;
    localparam int BYTE_W     = 8;

endpackage
`default_nettype wire

// File: rtl/poci_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : poci_shifter
//  Description : 8-bit load/shift register serialising read data MSB first.
//                Clear beats load, load beats shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module poci_shifter
    import spi_pkg::*;
(
    input  logic              sclk,
    input  logic              rstn,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_load_data,
    output logic              o_poci
);

    logic [BYTE_W-1:0] r_shift;

    // Load a fresh byte, or shift left filling with zeros once drained
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_shift <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_load_data;
        end else begin
            r_shift <= {r_shift[BYTE_W-2:0], 1'b0};
        end
    end

    // Output comes straight from the flop, never from the incoming byte
    assign o_poci = r_shift[BYTE_W-1];

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_bank
//  Description : Command decoder and configuration register array fed by the
//                SPI deserializer. Burst writes auto-increment; burst reads
//                are serialised onto poci.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                     sclk,
    input  logic                     rstn,
    input  logic [BYTE_W-1:0]        msg_byte,
    input  logic                     msg_valid,
    input  logic                     frame_clr,
    output logic                     poci,
    output logic [NUM_REGS*8-1:0]    regs_flat,
    output logic                     wr_strobe,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [BYTE_W-1:0]        wr_data,
    output logic                     err_oor
);

    // One extra bit so NUM_REGS=128 is representable
    localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [BYTE_W-1:0]   r_regs [NUM_REGS];
    logic                r_wr_strobe;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [BYTE_W-1:0]   r_wr_data;
    logic                r_err_oor;

    logic [ADDR_W-1:0]   w_rd_addr;
    logic [BYTE_W-1:0]   w_rd_data;
    logic                w_rd_in_range;
    logic                w_ptr_in_range;
    logic                w_reg_we;
    logic                w_sh_load;

    // The read command addresses the array directly; later read bytes use ptr
    assign w_rd_addr      = (r_state == IDLE) ? msg_byte[ADDR_W-1:0] : r_ptr;
    assign w_rd_in_range  = ({1'b0, w_rd_addr} < c_num_regs);
    assign w_ptr_in_range = ({1'b0, r_ptr} < c_num_regs);

    // Read mux; out-of-range addresses read back as zero
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_addr == ADDR_W'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    assign w_reg_we  = msg_valid && !frame_clr && (r_state == WRITE) && w_ptr_in_range;
    assign w_sh_load = msg_valid && (((r_state == IDLE) && !msg_byte[CMD_WR_BIT]) ||
                                     (r_state == READ));

    // Register array: only rstn clears it, frame boundaries leave it alone
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_reg_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_ptr == ADDR_W'(i)) begin
                    r_regs[i] <= msg_byte;
                end
            end
        end
    end

    // Frame FSM, address pointer, write reporting and sticky range error
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err_oor   <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (frame_clr) begin
                // Any byte arriving with the frame end is discarded
                r_state   <= IDLE;
                r_err_oor <= 1'b0;
            end else if (msg_valid) begin
                case (r_state)
                    IDLE: begin
                        if (msg_byte[CMD_WR_BIT]) begin
                            r_state <= WRITE;
                            r_ptr   <= msg_byte[ADDR_W-1:0];
                        end else begin
                            r_state <= READ;
                            r_ptr   <= msg_byte[ADDR_W-1:0] + 1'b1;
                            if (!w_rd_in_range) begin
                                r_err_oor <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        if (w_ptr_in_range) begin
                            r_wr_strobe <= 1'b1;
                            r_wr_addr   <= r_ptr;
                            r_wr_data   <= msg_byte;
                        end else begin
                            r_err_oor   <= 1'b1;
                        end
                        r_ptr <= r_ptr + 1'b1;
                    end
                    READ: begin
                        if (!w_rd_in_range) begin
                            r_err_oor <= 1'b1;
                        end
                        r_ptr <= r_ptr + 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    poci_shifter u_poci_shifter (
        .sclk        (sclk),
        .rstn        (rstn),
        .i_clr       (frame_clr),
        .i_load      (w_sh_load),
        .i_load_data (w_rd_data),
        .o_poci      (poci)
    );

    // Flatten the array for the analog/digital consumers
    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[8*g +: 8] = r_regs[g];
        end
    endgenerate

    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign err_oor   = r_err_oor;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_reg_bank
//  Description : Directed self-checking bench for spi_reg_bank (NUM_REGS=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bank;

    localparam int NUM_REGS = 16;

    logic                  sclk;
    logic                  rstn;
    logic [7:0]            msg_byte;
    logic                  msg_valid;
    logic                  frame_clr;
    logic                  poci;
    logic [NUM_REGS*8-1:0] regs_flat;
    logic                  wr_strobe;
    logic [6:0]            wr_addr;
    logic [7:0]            wr_data;
    logic                  err_oor;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;

    spi_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (8'h00)
    ) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .msg_byte  (msg_byte),
        .msg_valid (msg_valid),
        .frame_clr (frame_clr),
        .poci      (poci),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err_oor   (err_oor)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Count strobe pulses, sampled away from the active edge
    always @(negedge sclk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge sclk);
    endtask

    // Present one byte for exactly one rising edge; called at a negedge
    task automatic send(input logic [7:0] b);
        msg_byte  = b;
        msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        frame_clr = 1'b1;
        tick();
        frame_clr = 1'b0;
    endtask

    // Sample poci n times, one per cycle, oldest bit ends up most significant
    task automatic collect(input int n, output logic [15:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[14:0], poci};
            tick();
        end
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return regs_flat[8*i +: 8];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [15:0] bits;
        int          base_cnt;

        rstn = 1'b0; msg_byte = 8'h00; msg_valid = 1'b0; frame_clr = 1'b0;
        tick(); tick();
        chk("rst_regs",   regs_flat, '0);
        chk("rst_poci",   poci, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_waddr",  wr_addr, 0);
        chk("rst_wdata",  wr_data, 0);
        chk("rst_err",    err_oor, 0);
        rstn = 1'b1;
        tick();

        // Burst write 0x82, 0xA5, 0x3C
        send(8'h82);
        chk("bw_no_strobe_cmd", wr_strobe, 0);
        send(8'hA5);
        chk("bw_strobe1", wr_strobe, 1);
        chk("bw_addr1",   wr_addr, 7'd2);
        chk("bw_data1",   wr_data, 8'hA5);
        send(8'h3C);
        chk("bw_strobe2", wr_strobe, 1);
        chk("bw_addr2",   wr_addr, 7'd3);
        chk("bw_data2",   wr_data, 8'h3C);
        tick();
        chk("bw_strobe_end", wr_strobe, 0);
        chk("bw_reg2",    reg_at(2), 8'hA5);
        chk("bw_reg3",    reg_at(3), 8'h3C);
        chk("bw_cnt",     strobe_cnt, 2);
        chk("bw_err",     err_oor, 0);
        pulse_clr();

        // Burst read from 2: dummy byte lands exactly as the first byte drains
        base_cnt = strobe_cnt;
        send(8'h02);
        bits = '0;
        for (int k = 0; k < 16; k++) begin
            bits = {bits[14:0], poci};
            if (k == 7) begin
                msg_byte = 8'h00; msg_valid = 1'b1;
            end else begin
                msg_valid = 1'b0;
            end
            tick();
        end
        msg_valid = 1'b0;
        chk("br_bits", bits, 16'hA53C);
        chk("br_no_strobe", strobe_cnt, base_cnt);
        pulse_clr();

        // Last register, then out-of-range drop
        base_cnt = strobe_cnt;
        send(8'h8F);
        send(8'h11);
        chk("wr15_strobe", wr_strobe, 1);
        chk("wr15_addr",   wr_addr, 7'd15);
        send(8'h22);
        chk("oor_strobe",  wr_strobe, 0);
        chk("oor_err",     err_oor, 1);
        tick();
        chk("wr15_reg",    reg_at(15), 8'h11);
        chk("oor_reg0",    reg_at(0), 8'h00);
        chk("oor_cnt",     strobe_cnt, base_cnt + 1);
        pulse_clr();
        chk("oor_err_clr", err_oor, 0);

        // frame_clr together with a data byte in WRITE
        base_cnt = strobe_cnt;
        send(8'h84);
        msg_byte = 8'h77; msg_valid = 1'b1; frame_clr = 1'b1;
        tick();
        msg_valid = 1'b0; frame_clr = 1'b0;
        chk("fc_strobe", wr_strobe, 0);
        chk("fc_reg4",   reg_at(4), 8'h00);
        send(8'h81);
        chk("fc_cmd_no_strobe", wr_strobe, 0);
        send(8'h5A);
        chk("fc_next_strobe", wr_strobe, 1);
        chk("fc_next_addr",   wr_addr, 7'd1);
        chk("fc_next_data",   wr_data, 8'h5A);
        tick();
        chk("fc_reg1",   reg_at(1), 8'h5A);
        chk("fc_reg5",   reg_at(5), 8'h00);
        chk("fc_cnt",    strobe_cnt, base_cnt + 1);
        pulse_clr();

        // Truncate a read of reg3 (0x3C) three cycles in, then restart
        send(8'h03);
        collect(3, bits);
        chk("tr_head", bits, 16'h0001);
        chk("tr_pre_clr", poci, 1);
        pulse_clr();
        collect(4, bits);
        chk("tr_zeroed", bits, 16'h0000);
        send(8'h02);
        collect(8, bits);
        chk("tr_restart", bits, 16'h00A5);
        pulse_clr();

        // Read command aimed past the array
        send(8'h20);
        chk("rd_oor_err", err_oor, 1);
        collect(8, bits);
        chk("rd_oor_bits", bits, 16'h0000);
        pulse_clr();
        chk("rd_oor_clr", err_oor, 0);

        // Asynchronous reset in the middle of a burst write
        send(8'h80);
        send(8'h99);
        chk("ar_pre_strobe", wr_strobe, 1);
        msg_byte = 8'h55; msg_valid = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_regs",   regs_flat, '0);
        chk("ar_strobe", wr_strobe, 0);
        chk("ar_waddr",  wr_addr, 0);
        chk("ar_wdata",  wr_data, 0);
        chk("ar_err",    err_oor, 0);
        chk("ar_poci",   poci, 0);
        msg_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("ar_regs_after", regs_flat, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
